// File: rtl/sc_gametick_scheduler_if.sv
// ----------------------------------------------------------------------------
// sc_gametick_scheduler_if
//   Bundles the button/crash inputs and the strobe/status outputs of
//   sc_gametick_scheduler. Clock and reset stay plain module ports.
//
//   Signals
//     SC_GAMETICK_SCHEDULER_startButton_InLow  board -> sched  start button, active low
//     SC_GAMETICK_SCHEDULER_pause_InLow        board -> sched  pause level, active low
//     SC_GAMETICK_SCHEDULER_crash_InLow        board -> sched  crash indication, active low
//     SC_GAMETICK_SCHEDULER_T0_OutLow          sched -> board  shift strobe, 1-cycle low
//     SC_GAMETICK_SCHEDULER_level_Out          sched -> board  current level
//     SC_GAMETICK_SCHEDULER_running_Out        sched -> board  1 while in RUN
//     SC_GAMETICK_SCHEDULER_gameover_Out       sched -> board  1 while in OVER
//
//   Modports: master = board/bench side, slave = scheduler side.
// ----------------------------------------------------------------------------
interface sc_gametick_scheduler_if #(
  parameter int unsigned LEVEL_W = 2
);
  logic               SC_GAMETICK_SCHEDULER_startButton_InLow;
  logic               SC_GAMETICK_SCHEDULER_pause_InLow;
  logic               SC_GAMETICK_SCHEDULER_crash_InLow;
  logic               SC_GAMETICK_SCHEDULER_T0_OutLow;
  logic [LEVEL_W-1:0] SC_GAMETICK_SCHEDULER_level_Out;
  logic               SC_GAMETICK_SCHEDULER_running_Out;
  logic               SC_GAMETICK_SCHEDULER_gameover_Out;

  modport master (
    output SC_GAMETICK_SCHEDULER_startButton_InLow,
    output SC_GAMETICK_SCHEDULER_pause_InLow,
    output SC_GAMETICK_SCHEDULER_crash_InLow,
    input  SC_GAMETICK_SCHEDULER_T0_OutLow,
    input  SC_GAMETICK_SCHEDULER_level_Out,
    input  SC_GAMETICK_SCHEDULER_running_Out,
    input  SC_GAMETICK_SCHEDULER_gameover_Out
  );

  modport slave (
    input  SC_GAMETICK_SCHEDULER_startButton_InLow,
    input  SC_GAMETICK_SCHEDULER_pause_InLow,
    input  SC_GAMETICK_SCHEDULER_crash_InLow,
    output SC_GAMETICK_SCHEDULER_T0_OutLow,
    output SC_GAMETICK_SCHEDULER_level_Out,
    output SC_GAMETICK_SCHEDULER_running_Out,
    output SC_GAMETICK_SCHEDULER_gameover_Out
  );
endinterface

// File: rtl/sc_gametick_scheduler.sv
// ----------------------------------------------------------------------------
// sc_gametick_scheduler
//   Timebase for the background-scroll FSM: produces the active-low T0 shift
//   strobe every P = TICK_BASE >> level cycles and owns the game run state
//   (IDLE, RUN, PAUSE, OVER).
//
//   Ports
//     SC_GAMETICK_SCHEDULER_CLOCK_50     in  system clock
//     SC_GAMETICK_SCHEDULER_RESET_InHigh in  synchronous reset, active high
//     bus                                    sc_gametick_scheduler_if.slave
//                                            (start/pause/crash in,
//                                             T0/level/running/gameover out)
//
//   Build option
//     SC_GAMETICK_AUTOLEVEL_EN  defined: level rises every TICKS_PER_LEVEL
//                               strobes (saturating). Undefined: level fixed
//                               at 0, period fixed at TICK_BASE.
// ----------------------------------------------------------------------------
module sc_gametick_scheduler #(
  parameter int unsigned TICK_BASE       = 50000,
  parameter int unsigned COUNT_W         = 26,
  parameter int unsigned LEVEL_W         = 2,
  parameter int unsigned TICKS_PER_LEVEL = 16
) (
  input  logic                         SC_GAMETICK_SCHEDULER_CLOCK_50,
  input  logic                         SC_GAMETICK_SCHEDULER_RESET_InHigh,
  sc_gametick_scheduler_if.slave       bus
);

  if (TICKS_PER_LEVEL < 1 ||
      (TICK_BASE >> ((1 << LEVEL_W) - 1)) < 2) begin : g_param_chk
    $error("sc_gametick_scheduler: invalid TICK_BASE/LEVEL_W/TICKS_PER_LEVEL");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  localparam logic [COUNT_W-1:0] BASE = COUNT_W'(TICK_BASE);

  logic               clk, rst;
  state_t             state_q, state_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d, period;
  logic               t0_q, t0_d;
  logic               running_q, gameover_q;
  logic               start_q, rst_hold_q;
  logic               start_fall, term, advance, clear;

  assign clk = SC_GAMETICK_SCHEDULER_CLOCK_50;
  assign rst = SC_GAMETICK_SCHEDULER_RESET_InHigh;

  // rst_hold_q masks the first cycle after reset so that a button already
  // held low across reset release is not taken as a fresh press.
  assign start_fall = start_q & ~bus.SC_GAMETICK_SCHEDULER_startButton_InLow
                      & ~rst_hold_q;

`ifdef SC_GAMETICK_AUTOLEVEL_EN
  localparam int unsigned TW = $clog2(TICKS_PER_LEVEL + 1);
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [TW-1:0]      tick_q, tick_d;
  assign period = BASE >> level_q;
  assign bus.SC_GAMETICK_SCHEDULER_level_Out = level_q;
`else
  assign period = BASE;
  assign bus.SC_GAMETICK_SCHEDULER_level_Out = '0;
`endif

  assign term = (cnt_q == period - COUNT_W'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t0_d    = 1'b1;
    advance = 1'b0;
    clear   = 1'b0;
`ifdef SC_GAMETICK_AUTOLEVEL_EN
    level_d = level_q;
    tick_d  = tick_q;
`endif
    case (state_q)
      S_IDLE: begin
        clear = 1'b1;
        if (start_fall) state_d = S_RUN;
      end
      S_RUN: begin
        if (!bus.SC_GAMETICK_SCHEDULER_crash_InLow)      state_d = S_OVER;
        else if (!bus.SC_GAMETICK_SCHEDULER_pause_InLow) state_d = S_PAUSE;
        else                                             advance = 1'b1;
      end
      S_PAUSE: begin
        // The release edge already counts, so a pause held for N cycles
        // delays the next strobe by exactly N cycles.
        if (!bus.SC_GAMETICK_SCHEDULER_crash_InLow) state_d = S_OVER;
        else if (bus.SC_GAMETICK_SCHEDULER_pause_InLow) begin
          state_d = S_RUN;
          advance = 1'b1;
        end
      end
      S_OVER: begin
        if (start_fall) begin
          state_d = S_RUN;
          clear   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        clear   = 1'b1;
      end
    endcase

    if (advance) begin
      if (term) begin
        cnt_d = '0;
        t0_d  = 1'b0;
`ifdef SC_GAMETICK_AUTOLEVEL_EN
        if (tick_q == TW'(TICKS_PER_LEVEL - 1)) begin
          tick_d = '0;
          if (level_q != '1) level_d = level_q + LEVEL_W'(1);
        end else begin
          tick_d = tick_q + TW'(1);
        end
`endif
      end else begin
        cnt_d = cnt_q + COUNT_W'(1);
      end
    end

    if (clear) begin
      cnt_d = '0;
`ifdef SC_GAMETICK_AUTOLEVEL_EN
      tick_d  = '0;
      level_d = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      t0_q       <= 1'b1;
      running_q  <= 1'b0;
      gameover_q <= 1'b0;
      start_q    <= 1'b1;
      rst_hold_q <= 1'b1;
`ifdef SC_GAMETICK_AUTOLEVEL_EN
      level_q    <= '0;
      tick_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      t0_q       <= t0_d;
      running_q  <= (state_d == S_RUN);
      gameover_q <= (state_d == S_OVER);
      start_q    <= bus.SC_GAMETICK_SCHEDULER_startButton_InLow;
      rst_hold_q <= 1'b0;
`ifdef SC_GAMETICK_AUTOLEVEL_EN
      level_q    <= level_d;
      tick_q     <= tick_d;
`endif
    end
  end

  assign bus.SC_GAMETICK_SCHEDULER_T0_OutLow    = t0_q;
  assign bus.SC_GAMETICK_SCHEDULER_running_Out  = running_q;
  assign bus.SC_GAMETICK_SCHEDULER_gameover_Out = gameover_q;

endmodule

// File: tb/tb_sc_gametick_scheduler.sv
// ----------------------------------------------------------------------------
// tb_sc_gametick_scheduler
//   Directed bench for sc_gametick_scheduler with TICK_BASE=16, LEVEL_W=2,
//   TICKS_PER_LEVEL=4. Expectations follow SC_GAMETICK_AUTOLEVEL_EN.
// ----------------------------------------------------------------------------
module tb_sc_gametick_scheduler;
  localparam int TB  = 16;
  localparam int CW  = 8;
  localparam int LW  = 2;
  localparam int TPL = 4;
`ifdef SC_GAMETICK_AUTOLEVEL_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sc_gametick_scheduler_if #(.LEVEL_W(LW)) bus ();

  sc_gametick_scheduler #(
    .TICK_BASE      (TB),
    .COUNT_W        (CW),
    .LEVEL_W        (LW),
    .TICKS_PER_LEVEL(TPL)
  ) dut (
    .SC_GAMETICK_SCHEDULER_CLOCK_50    (clk),
    .SC_GAMETICK_SCHEDULER_RESET_InHigh(rst),
    .bus                               (bus)
  );

  int nchk  = 0;
  int nfail = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until T0 is seen low; n = steps taken, -1 if the budget expires.
  task automatic wait_t0(input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      step();
      if (bus.SC_GAMETICK_SCHEDULER_T0_OutLow === 1'b0) begin
        n = i;
        break;
      end
    end
  endtask

  // Expected spacing before strobe k (k >= 1) and level right after it.
  function automatic int exp_gap(input int k);
    int l;
    if (!AUTO) return TB;
    l = (k - 1) / TPL;
    if (l > 3) l = 3;
    return TB >> l;
  endfunction

  function automatic int exp_lvl(input int k);
    int l;
    if (!AUTO) return 0;
    l = k / TPL;
    if (l > 3) l = 3;
    return l;
  endfunction

  task automatic set_inputs(input logic s, input logic p, input logic c);
    bus.SC_GAMETICK_SCHEDULER_startButton_InLow = s;
    bus.SC_GAMETICK_SCHEDULER_pause_InLow       = p;
    bus.SC_GAMETICK_SCHEDULER_crash_InLow       = c;
  endtask

  // Ends sampled one step after the RUN-entry edge (cnt = 0).
  task automatic reset_and_start();
    rst = 1'b1;
    set_inputs(1'b1, 1'b1, 1'b1);
    step();
    rst = 1'b0;
    step();
    bus.SC_GAMETICK_SCHEDULER_startButton_InLow = 1'b0;
    step();
    bus.SC_GAMETICK_SCHEDULER_startButton_InLow = 1'b1;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    set_inputs(1'b1, 1'b1, 1'b1);
    step();
    nchk++;
    if (bus.SC_GAMETICK_SCHEDULER_T0_OutLow !== 1'b1 ||
        bus.SC_GAMETICK_SCHEDULER_level_Out !== LW'(0) ||
        bus.SC_GAMETICK_SCHEDULER_running_Out !== 1'b0 ||
        bus.SC_GAMETICK_SCHEDULER_gameover_Out !== 1'b0) begin
      nfail++;
      $display("FAIL reset_vals: T0=%b lvl=%0d run=%b over=%b, want 1 0 0 0",
               bus.SC_GAMETICK_SCHEDULER_T0_OutLow, bus.SC_GAMETICK_SCHEDULER_level_Out,
               bus.SC_GAMETICK_SCHEDULER_running_Out, bus.SC_GAMETICK_SCHEDULER_gameover_Out);
    end
    rst = 1'b0;
    step();
    step();
    nchk++;
    if (bus.SC_GAMETICK_SCHEDULER_running_Out !== 1'b0) begin
      nfail++;
      $display("FAIL idle_hold: running=%b want 0", bus.SC_GAMETICK_SCHEDULER_running_Out);
    end
    bus.SC_GAMETICK_SCHEDULER_startButton_InLow = 1'b0;
    step();
    bus.SC_GAMETICK_SCHEDULER_startButton_InLow = 1'b1;
    nchk++;
    if (bus.SC_GAMETICK_SCHEDULER_running_Out !== 1'b1) begin
      nfail++;
      $display("FAIL start_run: running=%b want 1", bus.SC_GAMETICK_SCHEDULER_running_Out);
    end
    wait_t0(40, n);
    nchk++;
    if (n !== 16) begin
      nfail++;
      $display("FAIL first_strobe: steps=%0d want 16", n);
    end
    step();
    nchk++;
    if (bus.SC_GAMETICK_SCHEDULER_T0_OutLow !== 1'b1) begin
      nfail++;
      $display("FAIL pulse_width: T0=%b want 1", bus.SC_GAMETICK_SCHEDULER_T0_OutLow);
    end
    wait_t0(40, n);
    nchk++;
    if (n !== 15) begin
      nfail++;
      $display("FAIL second_strobe: steps=%0d want 15", n);
    end
  endtask

  task automatic test_progression();
    int n;
    reset_and_start();
    for (int k = 1; k <= 20; k++) begin
      wait_t0(40, n);
      nchk++;
      if (n !== exp_gap(k)) begin
        nfail++;
        $display("FAIL gap_%0d: steps=%0d want %0d", k, n, exp_gap(k));
      end
      nchk++;
      if (bus.SC_GAMETICK_SCHEDULER_level_Out !== LW'(exp_lvl(k))) begin
        nfail++;
        $display("FAIL level_%0d: level=%0d want %0d", k,
                 bus.SC_GAMETICK_SCHEDULER_level_Out, exp_lvl(k));
      end
    end
  endtask

  task automatic test_pause();
    int n;
    reset_and_start();
    for (int i = 0; i < 10; i++) step();
    bus.SC_GAMETICK_SCHEDULER_pause_InLow = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      nchk++;
      if (bus.SC_GAMETICK_SCHEDULER_T0_OutLow !== 1'b1 ||
          bus.SC_GAMETICK_SCHEDULER_running_Out !== 1'b0) begin
        nfail++;
        $display("FAIL pause_hold_%0d: T0=%b run=%b want 1 0", i,
                 bus.SC_GAMETICK_SCHEDULER_T0_OutLow, bus.SC_GAMETICK_SCHEDULER_running_Out);
      end
    end
    bus.SC_GAMETICK_SCHEDULER_pause_InLow = 1'b1;
    step();
    nchk++;
    if (bus.SC_GAMETICK_SCHEDULER_running_Out !== 1'b1) begin
      nfail++;
      $display("FAIL pause_resume: running=%b want 1", bus.SC_GAMETICK_SCHEDULER_running_Out);
    end
    wait_t0(40, n);
    nchk++;
    if (n !== 5) begin
      nfail++;
      $display("FAIL pause_strobe: steps=%0d want 5", n);
    end
    // crash while paused goes straight to OVER
    bus.SC_GAMETICK_SCHEDULER_pause_InLow = 1'b0;
    step();
    bus.SC_GAMETICK_SCHEDULER_crash_InLow = 1'b0;
    step();
    set_inputs(1'b1, 1'b1, 1'b1);
    nchk++;
    if (bus.SC_GAMETICK_SCHEDULER_gameover_Out !== 1'b1) begin
      nfail++;
      $display("FAIL pause_crash: gameover=%b want 1", bus.SC_GAMETICK_SCHEDULER_gameover_Out);
    end
  endtask

  task automatic test_crash();
    int n;
    int lvl = AUTO ? 1 : 0;
    int pm1 = AUTO ? 7 : 15;
    reset_and_start();
    for (int k = 1; k <= 4; k++) wait_t0(40, n);
    for (int i = 0; i < pm1; i++) step();
    bus.SC_GAMETICK_SCHEDULER_crash_InLow = 1'b0;
    step();
    bus.SC_GAMETICK_SCHEDULER_crash_InLow = 1'b1;
    nchk++;
    if (bus.SC_GAMETICK_SCHEDULER_T0_OutLow !== 1'b1 ||
        bus.SC_GAMETICK_SCHEDULER_gameover_Out !== 1'b1 ||
        bus.SC_GAMETICK_SCHEDULER_running_Out !== 1'b0 ||
        bus.SC_GAMETICK_SCHEDULER_level_Out !== LW'(lvl)) begin
      nfail++;
      $display("FAIL crash_tc: T0=%b over=%b run=%b lvl=%0d want 1 1 0 %0d",
               bus.SC_GAMETICK_SCHEDULER_T0_OutLow, bus.SC_GAMETICK_SCHEDULER_gameover_Out,
               bus.SC_GAMETICK_SCHEDULER_running_Out, bus.SC_GAMETICK_SCHEDULER_level_Out, lvl);
    end
    wait_t0(20, n);
    nchk++;
    if (n !== -1 || bus.SC_GAMETICK_SCHEDULER_gameover_Out !== 1'b1) begin
      nfail++;
      $display("FAIL over_frozen: strobe_at=%0d over=%b want -1 1", n,
               bus.SC_GAMETICK_SCHEDULER_gameover_Out);
    end
    bus.SC_GAMETICK_SCHEDULER_startButton_InLow = 1'b0;
    step();
    bus.SC_GAMETICK_SCHEDULER_startButton_InLow = 1'b1;
    nchk++;
    if (bus.SC_GAMETICK_SCHEDULER_running_Out !== 1'b1 ||
        bus.SC_GAMETICK_SCHEDULER_gameover_Out !== 1'b0 ||
        bus.SC_GAMETICK_SCHEDULER_level_Out !== LW'(0)) begin
      nfail++;
      $display("FAIL restart: run=%b over=%b lvl=%0d want 1 0 0",
               bus.SC_GAMETICK_SCHEDULER_running_Out, bus.SC_GAMETICK_SCHEDULER_gameover_Out,
               bus.SC_GAMETICK_SCHEDULER_level_Out);
    end
    wait_t0(40, n);
    nchk++;
    if (n !== 16) begin
      nfail++;
      $display("FAIL restart_strobe: steps=%0d want 16", n);
    end
  endtask

  task automatic test_midrun_reset();
    int n;
    int lvl = AUTO ? 2 : 0;
    reset_and_start();
    for (int k = 1; k <= 8; k++) wait_t0(40, n);
    step();
    step();
    nchk++;
    if (bus.SC_GAMETICK_SCHEDULER_level_Out !== LW'(lvl) ||
        bus.SC_GAMETICK_SCHEDULER_running_Out !== 1'b1) begin
      nfail++;
      $display("FAIL pre_reset: lvl=%0d run=%b want %0d 1",
               bus.SC_GAMETICK_SCHEDULER_level_Out, bus.SC_GAMETICK_SCHEDULER_running_Out, lvl);
    end
    rst = 1'b1;
    bus.SC_GAMETICK_SCHEDULER_startButton_InLow = 1'b0;
    step();
    rst = 1'b0;
    nchk++;
    if (bus.SC_GAMETICK_SCHEDULER_T0_OutLow !== 1'b1 ||
        bus.SC_GAMETICK_SCHEDULER_level_Out !== LW'(0) ||
        bus.SC_GAMETICK_SCHEDULER_running_Out !== 1'b0 ||
        bus.SC_GAMETICK_SCHEDULER_gameover_Out !== 1'b0) begin
      nfail++;
      $display("FAIL midrun_reset: T0=%b lvl=%0d run=%b over=%b want 1 0 0 0",
               bus.SC_GAMETICK_SCHEDULER_T0_OutLow, bus.SC_GAMETICK_SCHEDULER_level_Out,
               bus.SC_GAMETICK_SCHEDULER_running_Out, bus.SC_GAMETICK_SCHEDULER_gameover_Out);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      nchk++;
      if (bus.SC_GAMETICK_SCHEDULER_running_Out !== 1'b0) begin
        nfail++;
        $display("FAIL held_start_%0d: running=%b want 0", i,
                 bus.SC_GAMETICK_SCHEDULER_running_Out);
      end
    end
    bus.SC_GAMETICK_SCHEDULER_startButton_InLow = 1'b1;
    step();
    bus.SC_GAMETICK_SCHEDULER_startButton_InLow = 1'b0;
    step();
    bus.SC_GAMETICK_SCHEDULER_startButton_InLow = 1'b1;
    nchk++;
    if (bus.SC_GAMETICK_SCHEDULER_running_Out !== 1'b1) begin
      nfail++;
      $display("FAIL repress: running=%b want 1", bus.SC_GAMETICK_SCHEDULER_running_Out);
    end
  endtask

  initial begin
    set_inputs(1'b1, 1'b1, 1'b1);
    test_reset();
    test_progression();
    test_pause();
    test_crash();
    test_midrun_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
